// File: rtl/bus_memory_unit_pkg.sv
// rtl/bus_memory_unit_pkg.sv - shared loader state encoding and default widths
package bus_memory_unit_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_ADDRESS_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/bus_memory_unit_ram_array.sv
// rtl/bus_memory_unit_ram_array.sv - word RAM with one synchronous write port and one asynchronous read port
module bus_memory_unit_ram_array
  import bus_memory_unit_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset so programs survive a CPU reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/bus_memory_unit.sv
// rtl/bus_memory_unit.sv - MAR, bus-side RAM access and program loader (optional MAR_OUTPUT_EN adds i_MAR_OUTPUT)
module bus_memory_unit
  import bus_memory_unit_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     i_CLOCK,
  input  logic                     i_RESET,
  inout  wire  [DATA_WIDTH-1:0]    BUS,
  input  logic                     i_MAR_LOAD,
  input  logic                     i_RAM_OUTPUT,
  input  logic                     i_RAM_WRITE,
`ifdef MAR_OUTPUT_EN
  input  logic                     i_MAR_OUTPUT,
`endif
  input  logic                     i_PROG_MODE,
  input  logic [DATA_WIDTH-1:0]    i_PROG_DATA,
  input  logic                     i_PROG_VALID,
  output logic                     o_PROG_READY,
  output logic                     o_PROG_DONE,
  output logic [ADDRESS_WIDTH-1:0] o_MAR
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = {ADDRESS_WIDTH{1'b1}};

  load_state_e              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] mar_q, mar_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic                     ready_q, ready_d;
  logic                     done_q, done_d;

  logic                     ram_we;
  logic [ADDRESS_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0]    ram_wdata;
  logic [DATA_WIDTH-1:0]    ram_rdata;

  logic                     bus_cmd_en;
  logic                     ram_oe;
  logic                     lo_oe;
  logic [ADDRESS_WIDTH-1:0] lo_val;

  // Bus commands only act in RUN and lose to both reset and a loader request
  assign bus_cmd_en = (state_q == ST_RUN) && !i_PROG_MODE && !i_RESET;
  assign ram_oe     = bus_cmd_en && i_RAM_OUTPUT;

  // Next-state, MAR, load pointer and RAM write-port mux
  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    ptr_d     = ptr_q;
    ram_we    = 1'b0;
    ram_waddr = mar_q;
    // Write-while-output stores the word being driven, taken directly from the RAM
    ram_wdata = i_RAM_OUTPUT ? ram_rdata : BUS;
    case (state_q)
      ST_RUN: begin
        if (i_PROG_MODE) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end else begin
          if (i_MAR_LOAD) mar_d = BUS[ADDRESS_WIDTH-1:0];
          if (i_RAM_WRITE) ram_we = 1'b1;
        end
      end
      ST_LOAD: begin
        if (i_PROG_VALID && ready_q) begin
          ram_we    = 1'b1;
          ram_waddr = ptr_q;
          ram_wdata = i_PROG_DATA;
          ptr_d     = ptr_q + 1'b1;
        end
        if (!i_PROG_MODE) begin
          state_d = ST_RUN;
        end else if (i_PROG_VALID && ready_q && ptr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!i_PROG_MODE) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    ready_d = (state_d == ST_LOAD);
    done_d  = (state_d == ST_DONE);
  end

  // Loader FSM state with registered handshake/status outputs
  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      state_q <= ST_RUN;
      mar_q   <= '0;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  bus_memory_unit_ram_array #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_ram (
    .clk    (i_CLOCK),
    .wr_en  (ram_we),
    .wr_addr(ram_waddr),
    .wr_data(ram_wdata),
    .rd_addr(mar_q),
    .rd_data(ram_rdata)
  );

  // Low address-width bits may carry the MAR; the RAM word takes precedence
`ifdef MAR_OUTPUT_EN
  assign lo_oe  = ram_oe || (bus_cmd_en && i_MAR_OUTPUT);
  assign lo_val = ram_oe ? ram_rdata[ADDRESS_WIDTH-1:0] : mar_q;
`else
  assign lo_oe  = ram_oe;
  assign lo_val = ram_rdata[ADDRESS_WIDTH-1:0];
`endif

  assign BUS[ADDRESS_WIDTH-1:0]          = lo_oe  ? lo_val : 'z;
  assign BUS[DATA_WIDTH-1:ADDRESS_WIDTH] = ram_oe ? ram_rdata[DATA_WIDTH-1:ADDRESS_WIDTH] : 'z;

  assign o_PROG_READY = ready_q;
  assign o_PROG_DONE  = done_q;
  assign o_MAR        = mar_q;

endmodule

// File: tb/tb_bus_memory_unit.sv
// tb/tb_bus_memory_unit.sv - directed self-checking bench for bus_memory_unit
module tb_bus_memory_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mar_load = 1'b0;
  logic       ram_output = 1'b0;
  logic       ram_write = 1'b0;
  logic       mar_output = 1'b0;
  logic       prog_mode = 1'b0;
  logic [7:0] prog_data = 8'h00;
  logic       prog_valid = 1'b0;
  logic       prog_ready;
  logic       prog_done;
  logic [3:0] mar;
  logic       drv_en = 1'b0;
  logic [7:0] drv_val = 8'h00;
  wire  [7:0] bus;

  int checks = 0;
  int failures = 0;

  assign bus = drv_en ? drv_val : 8'bzzzz_zzzz;

  always #5 clk = ~clk;

  bus_memory_unit dut (
    .i_CLOCK     (clk),
    .i_RESET     (rst),
    .BUS         (bus),
    .i_MAR_LOAD  (mar_load),
    .i_RAM_OUTPUT(ram_output),
    .i_RAM_WRITE (ram_write),
`ifdef MAR_OUTPUT_EN
    .i_MAR_OUTPUT(mar_output),
`endif
    .i_PROG_MODE (prog_mode),
    .i_PROG_DATA (prog_data),
    .i_PROG_VALID(prog_valid),
    .o_PROG_READY(prog_ready),
    .o_PROG_DONE (prog_done),
    .o_MAR       (mar)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_mar(input logic [7:0] v);
    drv_en = 1'b1; drv_val = v; mar_load = 1'b1;
    tick();
    drv_en = 1'b0; mar_load = 1'b0;
  endtask

  task automatic read_ram(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    set_mar(addr);
    ram_output = 1'b1;
    #1;
    check(tag, bus, exp);
    ram_output = 1'b0;
    #1;
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset_mar", {4'h0, mar}, 8'h00);
    check("reset_ready", {7'd0, prog_ready}, 8'h00);
    check("reset_done", {7'd0, prog_done}, 8'h00);

    // MAR load, write, asynchronous read
    set_mar(8'h05);
    check("mar_load", {4'h0, mar}, 8'h05);
    drv_en = 1'b1; drv_val = 8'hA7; ram_write = 1'b1;
    tick();
    drv_en = 1'b0; ram_write = 1'b0;
    ram_output = 1'b1;
    #1;
    check("ram_read_a7", bus, 8'hA7);
    ram_write = 1'b1;
    tick();
    ram_write = 1'b0;
    check("out_and_write", bus, 8'hA7);
    ram_output = 1'b0;
    #1;

    // full program load
    prog_mode = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      prog_data = 8'h10 + 8'(i);
      prog_valid = 1'b1;
      #1;
      check($sformatf("ready_%0d", i), {7'd0, prog_ready}, 8'h01);
      tick();
    end
    check("done_after_16", {7'd0, prog_done}, 8'h01);
    check("ready_low_done", {7'd0, prog_ready}, 8'h00);
    prog_data = 8'hFF;
    tick();
    check("done_held", {7'd0, prog_done}, 8'h01);
    prog_mode = 1'b0; prog_valid = 1'b0;
    tick();
    check("done_clear_run", {7'd0, prog_done}, 8'h00);
    read_ram(8'h0C, 8'h1C, "load_ram_c");
    read_ram(8'h00, 8'h10, "extra_byte_dropped");
    read_ram(8'h0F, 8'h1F, "load_ram_f");

    // partial load, bus commands ignored in LOAD
    prog_mode = 1'b1;
    tick();
    prog_valid = 1'b1;
    prog_data = 8'hAA; tick();
    prog_data = 8'hBB; tick();
    prog_data = 8'hCC; tick();
    prog_valid = 1'b0;
    drv_en = 1'b1; drv_val = 8'h07; mar_load = 1'b1; ram_write = 1'b1;
    tick();
    drv_en = 1'b0; mar_load = 1'b0; ram_write = 1'b0;
    check("load_ignores_mar", {4'h0, mar}, 8'h0F);
    prog_mode = 1'b0;
    tick();
    check("partial_ready_low", {7'd0, prog_ready}, 8'h00);
    check("partial_mar_kept", {4'h0, mar}, 8'h0F);
    read_ram(8'h0F, 8'h1F, "load_ignores_write");
    read_ram(8'h00, 8'hAA, "partial_0");
    read_ram(8'h01, 8'hBB, "partial_1");
    read_ram(8'h02, 8'hCC, "partial_2");
    read_ram(8'h03, 8'h13, "partial_3_kept");
    prog_mode = 1'b1;
    tick();
    prog_valid = 1'b1; prog_data = 8'h55;
    tick();
    prog_valid = 1'b0; prog_mode = 1'b0;
    tick();
    read_ram(8'h00, 8'h55, "reload_restart_0");
    read_ram(8'h01, 8'hBB, "reload_keep_1");

    // write uses pre-edge MAR while MAR loads the new value
    set_mar(8'h02);
    drv_en = 1'b1; drv_val = 8'h09; mar_load = 1'b1; ram_write = 1'b1;
    tick();
    drv_en = 1'b0; mar_load = 1'b0; ram_write = 1'b0;
    check("mar_new_value", {4'h0, mar}, 8'h09);
    read_ram(8'h02, 8'h09, "write_old_mar");
    read_ram(8'h09, 8'h19, "new_mar_not_written");

    // reset during LOAD
    set_mar(8'h05);
    prog_mode = 1'b1;
    tick();
    prog_valid = 1'b1; prog_data = 8'h77;
    tick();
    prog_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_ready", {7'd0, prog_ready}, 8'h00);
    check("rst_mar", {4'h0, mar}, 8'h00);
    check("rst_done", {7'd0, prog_done}, 8'h00);
    prog_mode = 1'b0;
    rst = 1'b0;
    tick();
    read_ram(8'h00, 8'h77, "ram_kept_after_rst");

`ifdef MAR_OUTPUT_EN
    set_mar(8'h06);
    mar_output = 1'b1;
    #1;
    check("mar_out_low", {4'h0, bus[3:0]}, 8'h06);
    ram_output = 1'b1;
    #1;
    check("ram_over_mar", bus, 8'h16);
    ram_output = 1'b0; mar_output = 1'b0;
    #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_memory_unit.md
Name: bus_memory_unit

Overview:
Memory side of the CPU main bus. Holds the memory address register (MAR) and the program/data RAM.
- The program counter, or any other bus driver, places an address on BUS; this block latches it into the MAR.
- On command, the block drives the addressed word back onto BUS, or writes BUS into RAM.
- A valid/ready program loader fills RAM sequentially from an external host while the CPU is halted.

Parameters:
DATA_WIDTH, 8, width of BUS and of each RAM word
ADDRESS_WIDTH, 4, MAR width; RAM depth is 2**ADDRESS_WIDTH words (derived, not overridable)

Ports:
i_CLOCK  input  1  system clock; all state changes on rising edge
i_RESET  input  1  synchronous reset, active-high
BUS  inout  DATA_WIDTH  main CPU bus
i_MAR_LOAD  input  1  latch BUS[ADDRESS_WIDTH-1:0] into MAR
i_RAM_OUTPUT  input  1  drive RAM[MAR] onto BUS
i_RAM_WRITE  input  1  write BUS into RAM[MAR]
i_PROG_MODE  input  1  request loader mode; CPU bus commands ignored while set
i_PROG_DATA  input  DATA_WIDTH  loader byte from host
i_PROG_VALID  input  1  host byte valid
o_PROG_READY  output  1  block accepts byte this cycle
o_PROG_DONE  output  1  all 2**ADDRESS_WIDTH words loaded
o_MAR  output  ADDRESS_WIDTH  current MAR value, for debug LEDs

Behaviour:
- Reset (i_RESET high at a clock edge): MAR=0, load pointer=0, state RUN, o_PROG_READY=0, o_PROG_DONE=0, BUS released (all bits z). RAM contents are not cleared.
- State RUN:
  - i_MAR_LOAD: MAR <= BUS[ADDRESS_WIDTH-1:0] at the next edge.
  - i_RAM_WRITE: RAM[MAR] <= BUS at the next edge.
  - i_RAM_OUTPUT: BUS = RAM[MAR] combinationally (asynchronous read, zero-cycle latency). Otherwise BUS is all z.
  - i_MAR_LOAD and i_RAM_WRITE together: the write uses the pre-edge MAR; MAR takes the new value.
  - i_RAM_OUTPUT and i_RAM_WRITE together: RAM stores the value being driven, so contents are unchanged. Legal, no error.
  - i_PROG_MODE high at an edge: go to LOAD and clear the pointer to 0.
- State LOAD:
  - o_PROG_READY=1.
  - A byte is accepted on an edge where i_PROG_VALID and o_PROG_READY are both high: RAM[ptr] <= i_PROG_DATA, ptr <= ptr+1.
  - Acceptance at ptr = 2**ADDRESS_WIDTH-1 goes to DONE; ptr wraps to 0.
  - Bus commands are ignored and BUS stays z.
  - i_PROG_MODE low goes to RUN at the next edge, including mid-load. Words already written are retained; the MAR is unchanged.
- State DONE: o_PROG_DONE=1, o_PROG_READY=0. Further valid bytes are dropped. i_PROG_MODE low goes to RUN.
- Mode priority: i_RESET > i_PROG_MODE > bus commands.
- o_MAR always reflects the MAR register.

Optional Feature:
Macro MAR_OUTPUT_EN.
- Defined: adds input port i_MAR_OUTPUT (1 bit). In RUN it drives BUS[ADDRESS_WIDTH-1:0]=MAR; upper bits are z. If i_RAM_OUTPUT is also high, the RAM drives the full bus and the MAR is not driven.
- Undefined: the port is absent and the MAR is never driven onto BUS.

Decomposition:
- Shared package: loader state encoding (RUN=2'd0, LOAD=2'd1, DONE=2'd2), default DATA_WIDTH/ADDRESS_WIDTH constants.
- One sub-module, ram_array:
  - 2**ADDRESS_WIDTH x DATA_WIDTH storage.
  - One synchronous write port and one asynchronous read port.
  - Write address/data muxed by the top between MAR/BUS and ptr/i_PROG_DATA.

Test Plan:
1. Reset, then drive BUS=8'h05 with i_MAR_LOAD for one cycle -> o_MAR=4'h5. Drive BUS=8'hA7 with i_RAM_WRITE; release, assert i_RAM_OUTPUT -> BUS reads 8'hA7 in the same cycle.
2. i_PROG_MODE=1, stream 16 bytes 8'h10..8'h1F with i_PROG_VALID held high -> o_PROG_READY high for 16 cycles, then o_PROG_DONE=1. In RUN, set MAR=4'hC and assert i_RAM_OUTPUT -> BUS=8'h1C.
3. In DONE, present a 17th byte 8'hFF -> not accepted; RAM[0] still 8'h10.
4. Drop i_PROG_MODE after 3 bytes (8'hAA, 8'hBB, 8'hCC) -> state RUN; RAM[0..2] hold those bytes and RAM[3] is unchanged. Re-entering LOAD restarts at address 0.
5. MAR=4'h2, same cycle i_MAR_LOAD with BUS=8'h09 and i_RAM_WRITE -> RAM[2]=8'h09, o_MAR=4'h9. i_RESET mid-LOAD -> RUN, o_PROG_READY=0, MAR=0.
6. With MAR_OUTPUT_EN: MAR=4'h6, i_MAR_OUTPUT -> BUS[3:0]=4'h6, BUS[7:4]=z. Adding i_RAM_OUTPUT -> BUS=RAM[6].
